// File: rtl/reg_file_pkg.sv
// reg_file_pkg
// Shared types and helpers for the multi-port register file.
//   be_merge   : overlay the enabled bytes of a new word onto an old word
//   wr_resolve : merge two write ports aimed at one entry and report
//                whether their byte masks overlap
// The helpers operate on the widest supported word (MAXBITS). Callers
// zero-extend into them and keep only their own low BITS bits.
package reg_file_pkg;

  localparam int MAXBITS  = 64;
  localparam int MAXBYTES = MAXBITS / 8;

  // Byte count of the default 16-bit configuration; instances with another
  // width derive their own count from their BITS parameter.
  localparam int DEF_BITS = 16;
  localparam int NBYTES   = DEF_BITS / 8;

  typedef struct packed {
    logic [MAXBITS-1:0] word;
    logic               coll;
  } wr_res_t;

  function automatic logic [MAXBITS-1:0] be_merge(
    input logic [MAXBITS-1:0]  old_w,
    input logic [MAXBITS-1:0]  new_w,
    input logic [MAXBYTES-1:0] be
  );
    logic [MAXBITS-1:0] res;
    res = old_w;
    for (int k = 0; k < MAXBYTES; k++) begin
      if (be[k]) res[8*k +: 8] = new_w[8*k +: 8];
    end
    return res;
  endfunction

  // Port 1 is applied last, so it wins on every byte both ports enable.
  function automatic wr_res_t wr_resolve(
    input logic [MAXBITS-1:0]  old_w,
    input logic                en0,
    input logic [MAXBYTES-1:0] be0,
    input logic [MAXBITS-1:0]  wd0,
    input logic                en1,
    input logic [MAXBYTES-1:0] be1,
    input logic [MAXBITS-1:0]  wd1
  );
    wr_res_t             r;
    logic [MAXBYTES-1:0] m0;
    logic [MAXBYTES-1:0] m1;
    m0     = en0 ? be0 : '0;
    m1     = en1 ? be1 : '0;
    r.word = be_merge(be_merge(old_w, wd0, m0), wd1, m1);
    r.coll = |(m0 & m1);
    return r;
  endfunction

endpackage

// File: rtl/reg_file_rd_port.sv
// reg_file_rd_port
// One registered read lane of the register file.
//   clk, rstn : clock and asynchronous active-low reset
//   re        : load enable for this lane; the lane holds when low
//   ra        : read address
//   stored    : current contents of every entry
//   merged    : every entry with this cycle's writes overlaid (bypass source)
//   rd        : registered read data
module reg_file_rd_port #(
  parameter int BITS     = 16,
  parameter int DEPTH    = 16,
  parameter int ADDR     = 4,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            re,
  input  logic [ADDR-1:0] ra,
  input  logic [BITS-1:0] stored [DEPTH],
  input  logic [BITS-1:0] merged [DEPTH],
  output logic [BITS-1:0] rd
);

  logic [BITS-1:0] sel;

  // Select the effective word for this address. Addresses with no matching
  // entry fall through to zero, and entry 0 is forced to zero when it is
  // hardwired.
  always_comb begin
    sel = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ra == ADDR'(i)) sel = (BYPASS != 0) ? merged[i] : stored[i];
    end
    if (ZERO_REG != 0 && ra == '0) sel = '0;
  end

  // Lane register: loads on a read request, otherwise keeps its last value
  // (a bulk clear of the entries leaves it untouched).
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)   rd <= '0;
    else if (re) rd <= sel;
  end

endmodule

// File: rtl/reg_file_mp.sv
// reg_file_mp
// Two-write-port, NRD-read-port register file with byte enables, optional
// write-to-read bypass, optional hardwired zero entry and synchronous clear.
//   clk, rstn           : clock and asynchronous active-low reset
//   CLR                 : clear every entry at the edge (beats any write)
//   WE0/WE1, WA0/WA1    : write enables and addresses
//   WD0/WD1, WBE0/WBE1  : write data and byte enables
//   RE, RA              : per-lane read enables and packed read addresses
//   RD                  : packed registered read data, one cycle after RE/RA
//   WERR                : one-cycle pulse for an overlapping same-entry write
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int BITS     = 16,
  parameter int DEPTH    = 16,
  parameter int ADDR     = 4,
  parameter int NRD      = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                CLR,
  input  logic                WE0,
  input  logic                WE1,
  input  logic [ADDR-1:0]     WA0,
  input  logic [ADDR-1:0]     WA1,
  input  logic [BITS-1:0]     WD0,
  input  logic [BITS-1:0]     WD1,
  input  logic [BITS/8-1:0]   WBE0,
  input  logic [BITS/8-1:0]   WBE1,
  input  logic [NRD-1:0]      RE,
  input  logic [NRD*ADDR-1:0] RA,
  output logic [NRD*BITS-1:0] RD,
  output logic                WERR
);

  logic [BITS-1:0]  mem [DEPTH];
  logic [BITS-1:0]  nxt [DEPTH];
  wr_res_t          res [DEPTH];
  logic [DEPTH-1:0] hit0;
  logic [DEPTH-1:0] hit1;
  logic [DEPTH-1:0] coll;
  logic [DEPTH-1:0] unused_hi;

  // Per-entry write merge. Out-of-range addresses match no entry and are
  // dropped; a hardwired entry 0 never accepts a write.
  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    assign hit0[i] = WE0 && (WA0 == ADDR'(i)) && (|WBE0) && !(ZERO_REG != 0 && i == 0);
    assign hit1[i] = WE1 && (WA1 == ADDR'(i)) && (|WBE1) && !(ZERO_REG != 0 && i == 0);
    assign res[i]  = wr_resolve(MAXBITS'(mem[i]),
                                hit0[i], MAXBYTES'(WBE0), MAXBITS'(WD0),
                                hit1[i], MAXBYTES'(WBE1), MAXBITS'(WD1));
    assign nxt[i]       = res[i].word[BITS-1:0];
    assign coll[i]      = res[i].coll;
    assign unused_hi[i] = ^res[i].word;
  end

  // Storage update: reset and clear zero every entry; otherwise every entry
  // takes its merged next value (unchanged when nothing hit it).
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (CLR) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= nxt[i];
    end
  end

  // Collision flag: at most one entry can see both ports, so an OR of the
  // per-entry overlap flags gives the cycle's collision, registered as a
  // one-cycle pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) WERR <= 1'b0;
    else       WERR <= |coll;
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    reg_file_rd_port #(
      .BITS(BITS), .DEPTH(DEPTH), .ADDR(ADDR),
      .BYPASS(BYPASS), .ZERO_REG(ZERO_REG)
    ) u_rd (
      .clk    (clk),
      .rstn   (rstn),
      .re     (RE[p]),
      .ra     (RA[p*ADDR +: ADDR]),
      .stored (mem),
      .merged (nxt),
      .rd     (RD[p*BITS +: BITS])
    );
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp
// Drives three register-file configurations from one stimulus stream:
//   A: defaults (bypass on, DEPTH 16)
//   B: bypass off
//   Z: hardwired zero entry, DEPTH 12
// A behavioural model applies each cycle's writes byte by byte and predicts
// the read lanes and collision flag of every configuration.
module tb_reg_file_mp;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        CLR = 1'b0;
  logic        WE0 = 1'b0, WE1 = 1'b0;
  logic [3:0]  WA0 = '0, WA1 = '0;
  logic [15:0] WD0 = '0, WD1 = '0;
  logic [1:0]  WBE0 = '0, WBE1 = '0;
  logic [1:0]  RE = '0;
  logic [7:0]  RA = '0;
  logic [31:0] rdA, rdB, rdZ;
  logic        werrA, werrB, werrZ;

  int tests  = 0;
  int failed = 0;

  logic [15:0] mdl   [3][16];
  logic [15:0] rdExp [3][2];
  logic        werrExp [3];
  int depthC [3] = '{16, 16, 12};
  int bypC   [3] = '{1, 0, 1};
  int zeroC  [3] = '{0, 0, 1};

  always #5 clk = ~clk;

  reg_file_mp dutA (
    .clk(clk), .rstn(rstn), .CLR(CLR), .WE0(WE0), .WE1(WE1), .WA0(WA0), .WA1(WA1),
    .WD0(WD0), .WD1(WD1), .WBE0(WBE0), .WBE1(WBE1), .RE(RE), .RA(RA),
    .RD(rdA), .WERR(werrA)
  );

  reg_file_mp #(.BYPASS(0)) dutB (
    .clk(clk), .rstn(rstn), .CLR(CLR), .WE0(WE0), .WE1(WE1), .WA0(WA0), .WA1(WA1),
    .WD0(WD0), .WD1(WD1), .WBE0(WBE0), .WBE1(WBE1), .RE(RE), .RA(RA),
    .RD(rdB), .WERR(werrB)
  );

  reg_file_mp #(.DEPTH(12), .ZERO_REG(1)) dutZ (
    .clk(clk), .rstn(rstn), .CLR(CLR), .WE0(WE0), .WE1(WE1), .WA0(WA0), .WA1(WA1),
    .WD0(WD0), .WD1(WD1), .WBE0(WBE0), .WBE1(WBE1), .RE(RE), .RA(RA),
    .RD(rdZ), .WERR(werrZ)
  );

  // One comparison: counts it, and on a miss counts the failure and reports it.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reset clears every entry, every lane and the collision flag.
  task automatic resetModel();
    for (int c = 0; c < 3; c++) begin
      for (int a = 0; a < 16; a++) mdl[c][a] = '0;
      rdExp[c][0] = '0;
      rdExp[c][1] = '0;
      werrExp[c]  = 1'b0;
    end
  endtask

  // Predict the outcome of the coming edge from the current inputs, then
  // commit the model state.
  task automatic modelStep();
    logic [15:0] nw [16];
    logic        we;
    logic [3:0]  wa, ra;
    logic [15:0] wd;
    logic [1:0]  be;
    for (int c = 0; c < 3; c++) begin
      for (int a = 0; a < 16; a++) nw[a] = mdl[c][a];
      for (int w = 0; w < 2; w++) begin
        we = (w == 0) ? WE0 : WE1;
        wa = (w == 0) ? WA0 : WA1;
        wd = (w == 0) ? WD0 : WD1;
        be = (w == 0) ? WBE0 : WBE1;
        if (we && int'(wa) < depthC[c] && !(zeroC[c] == 1 && wa == 0)) begin
          for (int k = 0; k < 2; k++) if (be[k]) nw[wa][8*k +: 8] = wd[8*k +: 8];
        end
      end
      werrExp[c] = WE0 && WE1 && (WA0 == WA1) && (int'(WA0) < depthC[c]) &&
                   !(zeroC[c] == 1 && WA0 == 0) && ((WBE0 & WBE1) != 0);
      for (int p = 0; p < 2; p++) begin
        if (RE[p]) begin
          ra = RA[p*4 +: 4];
          if (int'(ra) >= depthC[c] || (zeroC[c] == 1 && ra == 0)) rdExp[c][p] = '0;
          else if (bypC[c] == 1) rdExp[c][p] = nw[ra];
          else rdExp[c][p] = mdl[c][ra];
        end
      end
      for (int a = 0; a < 16; a++) mdl[c][a] = CLR ? 16'h0 : nw[a];
    end
  endtask

  // Compare every lane and flag of every configuration with the model.
  task automatic checkAll();
    logic [31:0] rdv;
    logic        wv;
    for (int c = 0; c < 3; c++) begin
      case (c)
        0:       begin rdv = rdA; wv = werrA; end
        1:       begin rdv = rdB; wv = werrB; end
        default: begin rdv = rdZ; wv = werrZ; end
      endcase
      for (int p = 0; p < 2; p++)
        checkOutput($sformatf("cfg%0d_rd%0d", c, p), {16'h0, rdv[p*16 +: 16]}, {16'h0, rdExp[c][p]});
      checkOutput($sformatf("cfg%0d_werr", c), {31'h0, wv}, {31'h0, werrExp[c]});
    end
  endtask

  // Drive one cycle of inputs, step the model, clock, and check after the edge.
  task automatic applyStimulus(
    input logic clr,
    input logic we0, input logic [3:0] wa0, input logic [15:0] wd0, input logic [1:0] be0,
    input logic we1, input logic [3:0] wa1, input logic [15:0] wd1, input logic [1:0] be1,
    input logic [1:0] re, input logic [3:0] ra0, input logic [3:0] ra1
  );
    CLR = clr;
    WE0 = we0; WA0 = wa0; WD0 = wd0; WBE0 = be0;
    WE1 = we1; WA1 = wa1; WD1 = wd1; WBE1 = be1;
    RE  = re;  RA  = {ra1, ra0};
    modelStep();
    @(posedge clk);
    #1;
    checkAll();
  endtask

  task automatic idleInputs();
    CLR = 0; WE0 = 0; WE1 = 0; WBE0 = 0; WBE1 = 0; RE = 0;
  endtask

  initial begin
    resetModel();
    repeat (2) @(posedge clk);
    #1;
    checkAll();
    rstn = 1'b1;

    // byte-enable write over an existing value
    applyStimulus(0, 1, 4'd5, 16'h1234, 2'b11, 0, 4'd0, 16'h0, 2'b00, 2'b00, 4'd0, 4'd0);
    applyStimulus(0, 1, 4'd5, 16'hABCD, 2'b01, 0, 4'd0, 16'h0, 2'b00, 2'b00, 4'd0, 4'd0);
    applyStimulus(0, 0, 4'd0, 16'h0,    2'b00, 0, 4'd0, 16'h0, 2'b00, 2'b01, 4'd5, 4'd0);
    checkOutput("be_write", {16'h0, rdA[15:0]}, 32'h12CD);

    // overlapping collision, then the pulse drops and the merged word reads back
    applyStimulus(0, 1, 4'd3, 16'h1111, 2'b11, 1, 4'd3, 16'h2222, 2'b10, 2'b00, 4'd0, 4'd0);
    checkOutput("werr_pulse", {31'h0, werrA}, 32'h1);
    applyStimulus(0, 0, 4'd0, 16'h0, 2'b00, 0, 4'd0, 16'h0, 2'b00, 2'b10, 4'd0, 4'd3);
    checkOutput("werr_drop", {31'h0, werrA}, 32'h0);
    checkOutput("coll_merge", {16'h0, rdA[31:16]}, 32'h2211);

    // disjoint masks on the same entry raise no flag
    applyStimulus(0, 1, 4'd3, 16'h1111, 2'b01, 1, 4'd3, 16'h2222, 2'b10, 2'b00, 4'd0, 4'd0);
    checkOutput("werr_disjoint", {31'h0, werrA}, 32'h0);

    // read-during-write on entry 7
    applyStimulus(0, 1, 4'd7, 16'h5A5A, 2'b11, 0, 4'd0, 16'h0, 2'b00, 2'b10, 4'd0, 4'd7);
    checkOutput("bypass_on", {16'h0, rdA[31:16]}, 32'h5A5A);
    checkOutput("bypass_off_old", {16'h0, rdB[31:16]}, 32'h0);
    applyStimulus(0, 0, 4'd0, 16'h0, 2'b00, 0, 4'd0, 16'h0, 2'b00, 2'b10, 4'd0, 4'd7);
    checkOutput("bypass_off_next", {16'h0, rdB[31:16]}, 32'h5A5A);

    // zero entry and out-of-range writes
    applyStimulus(0, 1, 4'd0, 16'hFFFF, 2'b11, 1, 4'd13, 16'hFFFF, 2'b11, 2'b00, 4'd0, 4'd0);
    applyStimulus(0, 0, 4'd0, 16'h0, 2'b00, 0, 4'd0, 16'h0, 2'b00, 2'b11, 4'd0, 4'd13);
    checkOutput("zero_reg_rd0", {16'h0, rdZ[15:0]}, 32'h0);
    checkOutput("range_rd13", {16'h0, rdZ[31:16]}, 32'h0);
    applyStimulus(0, 1, 4'd11, 16'hBEEF, 2'b11, 0, 4'd0, 16'h0, 2'b00, 2'b00, 4'd0, 4'd0);
    applyStimulus(0, 0, 4'd0, 16'h0, 2'b00, 0, 4'd0, 16'h0, 2'b00, 2'b01, 4'd11, 4'd0);
    checkOutput("last_entry", {16'h0, rdZ[15:0]}, 32'hBEEF);

    // clear beats a simultaneous write; an idle lane holds through it
    applyStimulus(1, 1, 4'd2, 16'h7777, 2'b11, 0, 4'd0, 16'h0, 2'b00, 2'b10, 4'd0, 4'd2);
    checkOutput("clr_hold", {16'h0, rdA[15:0]}, 32'hBEEF);
    applyStimulus(0, 0, 4'd0, 16'h0, 2'b00, 0, 4'd0, 16'h0, 2'b00, 2'b10, 4'd0, 4'd2);
    checkOutput("clr_wins", {16'h0, rdA[31:16]}, 32'h0);
    checkOutput("clr_hold2", {16'h0, rdA[15:0]}, 32'hBEEF);

    // reset in the middle of a cycle right after a collision
    applyStimulus(0, 1, 4'd4, 16'hCAFE, 2'b11, 1, 4'd4, 16'hF00D, 2'b11, 2'b11, 4'd5, 4'd7);
    idleInputs();
    #2;
    rstn = 1'b0;
    #1;
    resetModel();
    checkAll();
    @(posedge clk);
    #1;
    rstn = 1'b1;
    for (int a = 0; a < 16; a += 2)
      applyStimulus(0, 0, 4'd0, 16'h0, 2'b00, 0, 4'd0, 16'h0, 2'b00, 2'b11, 4'(a), 4'(a + 1));

    // randomised traffic with biased same-address collisions
    for (int n = 0; n < 400; n++) begin
      logic [3:0] a0, a1;
      a0 = 4'($urandom_range(0, 15));
      a1 = ($urandom_range(0, 3) == 0) ? a0 : 4'($urandom_range(0, 15));
      applyStimulus(($urandom_range(0, 31) == 0),
                    1'($urandom), a0, 16'($urandom), 2'($urandom),
                    1'($urandom), a1, 16'($urandom), 2'($urandom),
                    2'($urandom), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
